// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the fifo_stat FIFO:
//   depth_of     - entry count derived from the address width
//   ptr_inc      - ring-pointer increment with explicit wrap to zero
//   thresh_legal - elaboration-time legality check of the flag thresholds
// -----------------------------------------------------------------------------
package fifo_pkg;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Wrap is explicit so a non-power-of-two depth would still behave.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic bit thresh_legal(input int addr_w,
                                      input int afull_thresh,
                                      input int aempty_thresh);
    int depth;
    if (addr_w < 1 || addr_w > 30) return 1'b0;
    depth = 1 << addr_w;
    return (afull_thresh >= 1) && (afull_thresh <= depth) &&
           (aempty_thresh >= 0) && (aempty_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port register array: one synchronous write port, one
// asynchronous (combinational) read port.
// Ports:
//   aclk   - clock, write on rising edge
//   we     - write enable
//   waddr  - write address  [ADDR_W-1:0]
//   wdata  - write data     [WIDTH-1:0]
//   raddr  - read address   [ADDR_W-1:0]
//   rdata  - read data      [WIDTH-1:0], follows raddr combinationally
// -----------------------------------------------------------------------------
module fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              aclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; stale contents are never visible because
  // the pointers and count gate every read, and leaving it unreset lets it map
  // onto plain registers or distributed RAM.
  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_stat.sv
// -----------------------------------------------------------------------------
// fifo_stat
// Synchronous first-word-fall-through FIFO with occupancy count,
// programmable almost-full / almost-empty flags and synchronous flush.
// Optional feature macro: FIFO_ERR_FLAGS_EN enables sticky overflow and
// underflow flags; without it both outputs are tied low.
// Ports:
//   aclk, areset   - clock (rising edge), asynchronous active-high reset
//   flush          - synchronous clear, wins over same-cycle w_en / r_en
//   w_en, w_data   - push request and data
//   r_en           - pop request
//   r_data         - head entry, valid while empty = 0
//   full, empty    - occupancy limits
//   almost_full    - count >= AFULL_THRESH
//   almost_empty   - count <= AEMPTY_THRESH
//   count          - stored entries, 0 .. 2**ADDR_W
//   overflow       - sticky: push attempted while full
//   underflow      - sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module fifo_stat
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int ADDR_W        = 4,
  parameter int AFULL_THRESH  = 2**ADDR_W - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              flush,
  input  logic              w_en,
  input  logic [WIDTH-1:0]  w_data,
  input  logic              r_en,
  output logic [WIDTH-1:0]  r_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int            DEPTH     = int'(depth_of(ADDR_W));
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C   = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] AEMPTY_C  = (ADDR_W+1)'(AEMPTY_THRESH);

  if (!thresh_legal(ADDR_W, AFULL_THRESH, AEMPTY_THRESH) || WIDTH < 1) begin : g_bad_param
    $error("fifo_stat: illegal WIDTH/ADDR_W/threshold parameters");
  end

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] wr_ptr_inc, rd_ptr_inc;
  logic [ADDR_W:0]   count_nxt;
  logic [WIDTH-1:0]  r_data_nxt;
  logic [WIDTH-1:0]  ram_rdata;
  logic              w_fire, r_fire;

  assign w_fire     = w_en & ~full;
  assign r_fire     = r_en & ~empty;
  assign wr_ptr_inc = ADDR_W'(ptr_inc(32'(wr_ptr), DEPTH));
  assign rd_ptr_inc = ADDR_W'(ptr_inc(32'(rd_ptr), DEPTH));

  // The RAM is read at the entry *behind* the head so the word that follows a
  // pop is already available to load into the r_data register.
  fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .aclk  (aclk),
    .we    (w_fire & ~flush),
    .waddr (wr_ptr),
    .wdata (w_data),
    .raddr (rd_ptr_inc),
    .rdata (ram_rdata)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    unique case ({w_fire, r_fire})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Head register: on a pop it loads the next stored word; if the FIFO was
  // empty (or its only word leaves this cycle) a push bypasses straight in.
  always_comb begin
    r_data_nxt = r_data;
    if (r_fire && (count > CNT_ONE)) begin
      r_data_nxt = ram_rdata;
    end else if (w_fire && (empty || (r_fire && count == CNT_ONE))) begin
      r_data_nxt = w_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      r_data       <= '0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (w_fire) wr_ptr <= wr_ptr_inc;
      if (r_fire) rd_ptr <= rd_ptr_inc;
      count        <= count_nxt;
      full         <= (count_nxt == CNT_FULL);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
      r_data       <= r_data_nxt;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stat.sv
// -----------------------------------------------------------------------------
// tb_fifo_stat
// Directed bench for fifo_stat at WIDTH=8, ADDR_W=2 (depth 4), default
// thresholds (almost_full at count>=2, almost_empty at count<=1).
// Error-flag expectations follow whether FIFO_ERR_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_stat;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 2;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic             aclk = 1'b0;
  logic             areset;
  logic             flush;
  logic             w_en;
  logic [WIDTH-1:0] w_data;
  logic             r_en;
  logic [WIDTH-1:0] r_data;
  logic             full, empty, almost_full, almost_empty;
  logic [ADDR_W:0]  count;
  logic             overflow, underflow;

  int vectors = 0;
  int miscompares = 0;

  fifo_stat #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .flush        (flush),
    .w_en         (w_en),
    .w_data       (w_data),
    .r_en         (r_en),
    .r_data       (r_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input int cnt, input logic e,
                             input logic f, input logic ae, input logic af);
    check({tag, ".count"},        32'(count),        32'(cnt));
    check({tag, ".empty"},        32'(empty),        32'(e));
    check({tag, ".full"},         32'(full),         32'(f));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    check({tag, ".almost_full"},  32'(almost_full),  32'(af));
  endtask

  // One clock with the given inputs; outputs are stable 1 ns after the edge.
  task automatic tick(input logic w, input logic [WIDTH-1:0] d, input logic r,
                      input logic f);
    w_en = w; w_data = d; r_en = r; flush = f;
    @(posedge aclk);
    #1;
    w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
  endtask

  logic [WIDTH-1:0] q[$];

  initial begin
    areset = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = '0;
    repeat (3) @(posedge aclk);
    #1;
    check_flags("reset", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("reset.r_data",    32'(r_data),    32'h0);
    check("reset.overflow",  32'(overflow),  32'h0);
    check("reset.underflow", 32'(underflow), 32'h0);
    areset = 1'b0;

    // Fill to full.
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    check_flags("push1", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("push1.r_data", 32'(r_data), 32'h11);
    tick(1'b1, 8'h22, 1'b0, 1'b0);
    check_flags("push2", 2, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 8'h33, 1'b0, 1'b0);
    check_flags("push3", 3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 8'h44, 1'b0, 1'b0);
    check_flags("push4", 4, 1'b0, 1'b1, 1'b0, 1'b1);
    check("push4.r_data", 32'(r_data), 32'h11);
    tick(1'b1, 8'h55, 1'b0, 1'b0);
    check_flags("push_full", 4, 1'b0, 1'b1, 1'b0, 1'b1);
    check("push_full.overflow", 32'(overflow), 32'(ERR_EXP));

    // Drain in order.
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("pop1.r_data", 32'(r_data), 32'h22);
    check_flags("pop1", 3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("pop2.r_data", 32'(r_data), 32'h33);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("pop3.r_data", 32'(r_data), 32'h44);
    check_flags("pop3", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check_flags("pop4", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check_flags("pop_empty", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pop_empty.underflow", 32'(underflow), 32'(ERR_EXP));
    check("pop_empty.overflow_sticky", 32'(overflow), 32'(ERR_EXP));

    // Bypass into empty, then push+pop with a single entry.
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    check_flags("bypass", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bypass.r_data", 32'(r_data), 32'hA5);
    tick(1'b1, 8'h5A, 1'b1, 1'b0);
    check_flags("pushpop1", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pushpop1.r_data", 32'(r_data), 32'h5A);

    // Fill, then push+pop while full: only the pop fires.
    tick(1'b1, 8'h01, 1'b0, 1'b0);
    tick(1'b1, 8'h02, 1'b0, 1'b0);
    tick(1'b1, 8'h03, 1'b0, 1'b0);
    check_flags("refill", 4, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 8'hEE, 1'b1, 1'b0);
    check_flags("pushpop_full", 3, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pushpop_full.r_data", 32'(r_data), 32'h01);

    // Mixed traffic against a queue scoreboard; pointers wrap several times.
    q = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 12; i++) begin
      logic w, r, wf, rf;
      logic [WIDTH-1:0] d;
      w = (i % 3) != 2;
      r = (i % 2) == 1;
      d = 8'(8'h80 + i);
      wf = w && (q.size() < 4);
      rf = r && (q.size() > 0);
      tick(w, d, r, 1'b0);
      if (rf) void'(q.pop_front());
      if (wf) q.push_back(d);
      check($sformatf("mix%0d.count", i), 32'(count), 32'(q.size()));
      if (q.size() > 0) check($sformatf("mix%0d.r_data", i), 32'(r_data), 32'(q[0]));
    end
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      check($sformatf("drain%0d.r_data", i), 32'(r_data), 32'(q[0]));
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      void'(q.pop_front());
    end
    check_flags("drained", 0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Flush at count 3 with a competing push.
    tick(1'b1, 8'hC1, 1'b0, 1'b0);
    tick(1'b1, 8'hC2, 1'b0, 1'b0);
    tick(1'b1, 8'hC3, 1'b0, 1'b0);
    check_flags("preflush", 3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 8'hFF, 1'b0, 1'b1);
    check_flags("flush", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush.overflow",  32'(overflow),  32'h0);
    check("flush.underflow", 32'(underflow), 32'h0);
    tick(1'b1, 8'h42, 1'b0, 1'b0);
    check_flags("postflush", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("postflush.r_data", 32'(r_data), 32'h42);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check_flags("postflush_pop", 0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Push+pop while empty: only the push fires.
    tick(1'b1, 8'h66, 1'b1, 1'b0);
    check_flags("pushpop_empty", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pushpop_empty.r_data", 32'(r_data), 32'h66);
    check("pushpop_empty.underflow", 32'(underflow), 32'(ERR_EXP));

    // Asynchronous reset between edges.
    tick(1'b1, 8'h10, 1'b0, 1'b0);
    tick(1'b1, 8'h20, 1'b0, 1'b0);
    #2;
    areset = 1'b1;
    #1;
    check_flags("areset", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("areset.r_data",    32'(r_data),    32'h0);
    check("areset.underflow", 32'(underflow), 32'h0);
    @(posedge aclk);
    #3;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    tick(1'b1, 8'h77, 1'b0, 1'b0);
    check_flags("post_reset", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_reset.r_data", 32'(r_data), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
